uart_serial: RTL and testbench

Clocked, parametrised successor to the behavioural console UART. It keeps the CPU-side contract: `indata`/`TX_n` for writes, `RD_n`/`outdata` for reads, both strobes active on the falling edge.
- Adds real 8N1-style serial TX and RX engines with a programmable bit period.
- Adds independent TX and RX FIFOs, status flags and sticky error reporting.
- Sits between the CPU bus decode and the board's serial pins (or a testbench terminal model).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_serial.sv | 208 ++++++++++++++++++++
 tb/tb_uart_serial.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : FSM state encoding and counter-width helpers for uart_serial
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int baud_cnt_w(input int clk_div);
    return $clog2(clk_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_fifo : first-word-fall-through FIFO, binary pointers with a wrap bit
// Revision  : 1.0
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a push on a full FIFO still lands.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_serial : FIFO-buffered serial UART with strobe-driven CPU interface.
//               Define UART_LOOPBACK_EN to feed the receiver from txd.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module uart_serial
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] indata,
  input  logic              TX_n,
  input  logic              RD_n,
  output logic [DATA_W-1:0] outdata,
  input  logic              err_clr,
  output logic              txd,
  input  logic              rxd,
  output logic              rx_ready,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              rx_overrun,
  output logic              tx_overflow,
  output logic              frame_err
);

  localparam int BIT_W  = bit_cnt_w(DATA_W);
  localparam int BAUD_W = baud_cnt_w(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  logic              tx_n_q, rd_n_q, wr_ev, rd_ev;
  logic              tx_pop, tx_empty;
  logic [DATA_W-1:0] tx_rdata;
  logic              rx_push, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_rdata;
  logic              rx_src, sync1_q, sync2_q, rx_last_q;
  logic              frame_set;

  uart_state_t       tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] tx_baud_q, tx_baud_d, rx_baud_q, rx_baud_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] outdata_q, outdata_d;
  logic              txd_q, txd_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_overflow_q, tx_overflow_d;
  logic              frame_err_q, frame_err_d;

  assign wr_ev = tx_n_q & ~TX_n;
  assign rd_ev = rd_n_q & ~RD_n;

`ifdef UART_LOOPBACK_EN
  assign rx_src = txd_q;
`else
  assign rx_src = rxd;
`endif

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(wr_ev), .pop(tx_pop),
    .wdata(indata), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rd_ev),
    .wdata(rx_shift_d), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  // Transmitter: a new frame starts in the cycle STOP ends, so queued bytes go out gap-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      IDLE: begin
        tx_baud_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_state_d = START;
        end
      end
      START: if (tx_baud_q == BAUD_LAST) begin
        tx_baud_d  = '0;
        tx_bit_d   = '0;
        tx_state_d = DATA;
      end
      DATA: if (tx_baud_q == BAUD_LAST) begin
        tx_baud_d  = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 1'b1;
        if (tx_bit_q == BIT_LAST) tx_state_d = STOP;
      end
      STOP: if (tx_baud_q == BAUD_LAST) begin
        tx_baud_d  = '0;
        tx_state_d = IDLE;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_state_d = START;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    txd_d = (tx_state_d == START) ? 1'b0 :
            (tx_state_d == DATA)  ? tx_shift_d[0] : 1'b1;
  end

  // Receiver: all sampling uses sync2_q; rx_last_q only detects the start edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_baud_d = '0;
        if (rx_last_q && !sync2_q) rx_state_d = START;
      end
      START: if (rx_baud_q == BAUD_HALF) begin
        rx_baud_d  = '0;
        rx_bit_d   = '0;
        rx_state_d = sync2_q ? IDLE : DATA;
      end
      DATA: if (rx_baud_q == BAUD_LAST) begin
        rx_baud_d  = '0;
        rx_shift_d = {sync2_q, rx_shift_q[DATA_W-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == BIT_LAST) rx_state_d = STOP;
      end
      STOP: if (rx_baud_q == BAUD_LAST) begin
        rx_baud_d  = '0;
        rx_state_d = IDLE;
        rx_push    = sync2_q;
        frame_set  = !sync2_q;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    outdata_d     = (rd_ev && !rx_empty) ? rx_rdata : outdata_q;
    tx_overflow_d = (tx_overflow_q & ~err_clr) | (wr_ev & tx_full & ~tx_pop);
    rx_overrun_d  = (rx_overrun_q & ~err_clr) | (rx_push & rx_full & ~rd_ev);
    frame_err_d   = (frame_err_q & ~err_clr) | frame_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_last_q     <= 1'b1;
      tx_state_q    <= IDLE;
      tx_baud_q     <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      txd_q         <= 1'b1;
      rx_state_q    <= IDLE;
      rx_baud_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      outdata_q     <= '0;
      tx_overflow_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_n_q        <= TX_n;
      rd_n_q        <= RD_n;
      sync1_q       <= rx_src;
      sync2_q       <= sync1_q;
      rx_last_q     <= sync2_q;
      tx_state_q    <= tx_state_d;
      tx_baud_q     <= tx_baud_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      txd_q         <= txd_d;
      rx_state_q    <= rx_state_d;
      rx_baud_q     <= rx_baud_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      outdata_q     <= outdata_d;
      tx_overflow_q <= tx_overflow_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign txd         = txd_q;
  assign outdata     = outdata_q;
  assign rx_ready    = ~rx_empty;
  assign tx_busy     = ~tx_empty | (tx_state_q != IDLE);
  assign tx_overflow = tx_overflow_q;
  assign rx_overrun  = rx_overrun_q;
  assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_serial : scoreboard bench; instance a uses CLK_DIV=4, instance b 16.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  logic [7:0] a_indata = '0, b_indata = '0;
  logic a_tx_n = 1'b1, a_rd_n = 1'b1, a_err_clr = 1'b0, a_rxd = 1'b1;
  logic b_tx_n = 1'b1, b_rd_n = 1'b1, b_err_clr = 1'b0, b_rxd = 1'b1;
  logic [7:0] a_outdata, b_outdata;
  logic a_txd, a_rx_ready, a_tx_full, a_tx_busy, a_rx_overrun, a_tx_overflow, a_frame_err;
  logic b_txd, b_rx_ready, b_tx_full, b_tx_busy, b_rx_overrun, b_tx_overflow, b_frame_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_tx[$];
  logic [7:0] sb_rx[$];

  uart_serial #(.DATA_W(8), .CLK_DIV(4), .FIFO_DEPTH(8)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .indata(a_indata), .TX_n(a_tx_n), .RD_n(a_rd_n),
    .outdata(a_outdata), .err_clr(a_err_clr), .txd(a_txd), .rxd(a_rxd),
    .rx_ready(a_rx_ready), .tx_full(a_tx_full), .tx_busy(a_tx_busy),
    .rx_overrun(a_rx_overrun), .tx_overflow(a_tx_overflow), .frame_err(a_frame_err)
  );

  uart_serial #(.DATA_W(8), .CLK_DIV(16), .FIFO_DEPTH(8)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .indata(b_indata), .TX_n(b_tx_n), .RD_n(b_rd_n),
    .outdata(b_outdata), .err_clr(b_err_clr), .txd(b_txd), .rxd(b_rxd),
    .rx_ready(b_rx_ready), .tx_full(b_tx_full), .tx_busy(b_tx_busy),
    .rx_overrun(b_rx_overrun), .tx_overflow(b_tx_overflow), .frame_err(b_frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_write(input logic [7:0] v, input bit keep, input int hold);
    @(negedge clk);
    a_indata = v;
    a_tx_n   = 1'b0;
    if (keep) sb_tx.push_back(v);
    repeat (hold) @(negedge clk);
    a_tx_n = 1'b1;
  endtask

  task automatic a_read(output logic [7:0] v);
    @(negedge clk);
    a_rd_n = 1'b0;
    @(negedge clk);
    a_rd_n = 1'b1;
    v = a_outdata;
  endtask

  task automatic b_send(input logic [7:0] v, input logic stop, input bit keep);
    @(negedge clk);
    b_rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b_rxd = v[i];
      repeat (16) @(negedge clk);
    end
    b_rxd = stop;
    repeat (16) @(negedge clk);
    b_rxd = 1'b1;
    if (keep) sb_rx.push_back(v);
  endtask

  task automatic b_read(output logic [7:0] v);
    @(negedge clk);
    b_rd_n = 1'b0;
    @(negedge clk);
    b_rd_n = 1'b1;
    v = b_outdata;
  endtask

  task automatic a_wait_idle(input int limit);
    int cyc;
    cyc = 0;
    while (a_tx_busy === 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("tx_drained", a_tx_busy, 1'b0);
  endtask

  task automatic err_pulse_a();
    @(negedge clk); a_err_clr = 1'b1;
    @(negedge clk); a_err_clr = 1'b0;
  endtask

  task automatic err_pulse_b();
    @(negedge clk); b_err_clr = 1'b1;
    @(negedge clk); b_err_clr = 1'b0;
  endtask

  // Decodes frames on a_txd (4 samples per bit) and scores them against sb_tx.
  initial begin : tx_monitor
    int gap;
    bit b2b;
    bit shape_ok;
    logic [7:0] rx_byte;
    logic [31:0] exp;
    gap = 0;
    b2b = 1'b0;
    @(posedge reset_n);
    forever begin
      @(negedge clk);
      if (a_txd === 1'b0) begin
        if (b2b) check("tx_b2b_gap", gap, 0);
        shape_ok = 1'b1;
        for (int k = 1; k < 4; k++) begin
          @(negedge clk);
          if (a_txd !== 1'b0) shape_ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          rx_byte[i] = a_txd;
          for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if (a_txd !== rx_byte[i]) shape_ok = 1'b0;
          end
        end
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (a_txd !== 1'b1) shape_ok = 1'b0;
        end
        check("tx_frame_shape", shape_ok, 1'b1);
        exp = (sb_tx.size() != 0) ? {24'd0, sb_tx.pop_front()} : 32'h100;
        check("tx_byte", {24'd0, rx_byte}, exp);
        b2b = (sb_tx.size() != 0);
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  initial begin : main
    logic [7:0] v;
    int cyc;
    string msg;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_a_txd", a_txd, 1'b1);
    check("rst_a_outdata", a_outdata, 8'h00);
    check("rst_a_flags", {a_rx_ready, a_tx_full, a_tx_busy, a_rx_overrun, a_tx_overflow, a_frame_err}, 6'b0);
    check("rst_b_txd", b_txd, 1'b1);
    check("rst_b_outdata", b_outdata, 8'h00);
    check("rst_b_flags", {b_rx_ready, b_tx_full, b_tx_busy, b_rx_overrun, b_tx_overflow, b_frame_err}, 6'b0);

`ifdef UART_LOOPBACK_EN
    msg = "Hello!\r\n";
    for (int i = 0; i < 8; i++) begin
      a_write(msg[i], 1'b1, 1);
      sb_rx.push_back(msg[i]);
    end
    a_wait_idle(8 * 40 + 50);
    repeat (4) @(negedge clk);
    check("lb_rx_ready", a_rx_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      a_read(v);
      check("lb_byte", v, (sb_rx.size() != 0) ? {24'd0, sb_rx.pop_front()} : 32'h100);
    end
    check("lb_rx_empty", a_rx_ready, 1'b0);
    check("lb_errors", {a_rx_overrun, a_tx_overflow, a_frame_err}, 3'b0);
`else
    msg = "";
    // Single byte: frame timing and busy window.
    a_write(8'h48, 1'b1, 1);
    check("tx_busy_after_push", a_tx_busy, 1'b1);
    cyc = 0;
    while (a_txd !== 1'b0 && cyc < 20) begin @(negedge clk); cyc++; end
    check("tx_start_seen", a_txd, 1'b0);
    cyc = 0;
    while (a_tx_busy === 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check("tx_busy_cycles", cyc, 40);
    repeat (8) @(negedge clk);

    // Fill the TX FIFO behind a busy shifter; the 10th write overflows.
    for (int i = 0; i < 10; i++) begin
      a_write(8'(($urandom & 8'hFF) ^ i), i < 9, 1);
      if (i == 8) begin
        check("tx_full_after_9", a_tx_full, 1'b1);
        check("tx_no_overflow_9", a_tx_overflow, 1'b0);
      end
    end
    check("tx_overflow_10", a_tx_overflow, 1'b1);
    a_wait_idle(9 * 40 + 50);
    check("tx_overflow_sticky", a_tx_overflow, 1'b1);
    err_pulse_a();
    check("tx_overflow_clr", a_tx_overflow, 1'b0);

    // A strobe held low for several cycles gives exactly one frame.
    a_write(8'h3C, 1'b1, 6);
    a_wait_idle(100);
    repeat (10) @(negedge clk);
    check("tx_sb_empty", sb_tx.size(), 0);

    // RX: two good frames.
    b_send(8'h65, 1'b1, 1'b1);
    b_send(8'h21, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("rx_ready", b_rx_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      b_read(v);
      check("rx_byte", v, (sb_rx.size() != 0) ? {24'd0, sb_rx.pop_front()} : 32'h100);
    end
    check("rx_drained", b_rx_ready, 1'b0);
    b_read(v);
    check("rx_empty_read_holds", v, 8'h21);

    // Stop bit low: frame error, nothing stored.
    b_send(8'h5A, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("frame_err_set", b_frame_err, 1'b1);
    check("frame_err_no_data", b_rx_ready, 1'b0);
    err_pulse_b();
    check("frame_err_clr", b_frame_err, 1'b0);
    b_send(8'h33, 1'b1, 1'b1);
    b_read(v);
    check("rx_after_ferr", v, (sb_rx.size() != 0) ? {24'd0, sb_rx.pop_front()} : 32'h100);

    // Short low glitch is a false start.
    @(negedge clk);
    b_rxd = 1'b0;
    repeat (4) @(negedge clk);
    b_rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_quiet", {b_frame_err, b_rx_overrun, b_rx_ready}, 3'b0);

    // Nine frames into an 8-deep FIFO: the 9th overruns.
    for (int i = 0; i < 9; i++) begin
      b_send(8'($urandom_range(0, 255)), 1'b1, i < 8);
      if (i == 7) check("rx_no_overrun_8", b_rx_overrun, 1'b0);
    end
    check("rx_overrun", b_rx_overrun, 1'b1);
    for (int i = 0; i < 8; i++) begin
      b_read(v);
      check("rx_fifo_byte", v, (sb_rx.size() != 0) ? {24'd0, sb_rx.pop_front()} : 32'h100);
    end
    check("rx_fifo_empty", b_rx_ready, 1'b0);
    err_pulse_b();
    check("rx_overrun_clr", b_rx_overrun, 1'b0);

    // Reset in the middle of a frame forces txd high without a clock edge.
    @(negedge clk);
    b_indata = 8'h00;
    b_tx_n   = 1'b0;
    @(negedge clk);
    b_tx_n = 1'b1;
    cyc = 0;
    while (b_txd !== 1'b0 && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_txd", b_txd, 1'b1);
    check("async_rst_busy", b_tx_busy, 1'b0);
    check("async_rst_outdata", b_outdata, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
